// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply sequencer.
// Holds the sequencer state encoding, the default geometry and widths, and the
// adder-tree depth derived from the PE array size.
package matmul_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain,
        StFin
    } seq_state_e;

    localparam int unsigned DefRows         = 64;
    localparam int unsigned DefCols         = 64;
    localparam int unsigned DefInAddrWidth  = 6;
    localparam int unsigned DefOutAddrWidth = 12;
    localparam int unsigned DefRdLat        = 1;

    // One adder-tree layer per halving of the PE array.
    localparam int unsigned ArraySize = 128;
    localparam int unsigned TreeLat   = $clog2(ArraySize);

endpackage

// File: rtl/matmul_valid_pipe.sv
// Shadow pipeline that follows each issued read through memory and adder-tree
// latency. Shifts every cycle; a stage's tag only advances alongside a valid
// entry, so the output tag holds the last written address during bubbles.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset, clears valids and tags
//   valid_i      entry pushed this cycle is a real issue
//   tag_i        output-memory address of the pushed entry
//   valid_o      last-stage valid
//   tag_o        last-stage tag (holds while not valid)
//   any_valid_o  some stage holds a valid entry
module matmul_valid_pipe #(
    parameter int unsigned DEPTH = 8,  // must be >= 2
    parameter int unsigned TAG_W = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             valid_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             any_valid_o
);

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= '0;
            end
        end else begin
            valid_q  <= {valid_q[DEPTH-2:0], valid_i};
            tag_q[0] <= valid_i ? tag_i : tag_q[0];
            for (int i = 1; i < DEPTH; i++) begin
                tag_q[i] <= valid_q[i-1] ? tag_q[i-1] : tag_q[i];
            end
        end
    end

    assign valid_o     = valid_q[DEPTH-1];
    assign tag_o       = tag_q[DEPTH-1];
    assign any_valid_o = |valid_q;

endmodule

// File: rtl/matmul_sequencer.sv
// Controller for one full matrix-multiply pass over the PE array / adder tree.
// Issues one (row, col) read pair per cycle to memories A and B, tracks the
// datapath latency with a shadow pipeline, and writes each dot product to the
// output memory at row*COLS+col.
// Optional: define MATMUL_SEQ_PERF_CNT_EN to add cycle_count_o / pause_count_o.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   start_i             pass request, only sampled in idle
//   pause_i             suppresses new issues while high (RUN only)
//   en_a_o/en_b_o       input-memory read enables
//   addr_a_o/addr_b_o   row / column index
//   en_out_o/we_out_o   output-memory enable / write strobe
//   addr_out_o          result address
//   busy_o, done_o      pass in progress / one-cycle completion pulse
//   cycle_count_o       (perf) busy cycles of the last pass
//   pause_count_o       (perf) paused RUN cycles of the last pass
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter int unsigned ROWS           = DefRows,
    parameter int unsigned COLS           = DefCols,
    parameter int unsigned IN_ADDR_WIDTH  = DefInAddrWidth,
    parameter int unsigned OUT_ADDR_WIDTH = DefOutAddrWidth,
    parameter int unsigned RD_LAT         = DefRdLat,
    parameter int unsigned TREE_LAT       = TreeLat
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic                      pause_i,
    output logic                      en_a_o,
    output logic                      en_b_o,
    output logic [IN_ADDR_WIDTH-1:0]  addr_a_o,
    output logic [IN_ADDR_WIDTH-1:0]  addr_b_o,
    output logic                      en_out_o,
    output logic                      we_out_o,
    output logic [OUT_ADDR_WIDTH-1:0] addr_out_o,
    output logic                      busy_o,
    output logic                      done_o
`ifdef MATMUL_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]               cycle_count_o,
    output logic [31:0]               pause_count_o
`endif
);

    localparam int unsigned PipeDepth = RD_LAT + TREE_LAT;
    localparam logic [IN_ADDR_WIDTH-1:0] RowLast = IN_ADDR_WIDTH'(ROWS - 1);
    localparam logic [IN_ADDR_WIDTH-1:0] ColLast = IN_ADDR_WIDTH'(COLS - 1);

    seq_state_e state_q, state_d;
    logic [IN_ADDR_WIDTH-1:0]  row_q, row_d;
    logic [IN_ADDR_WIDTH-1:0]  col_q, col_d;
    logic [OUT_ADDR_WIDTH-1:0] tag_q, tag_d;
    logic                      issue;
    logic                      any_valid;
    logic                      busy;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            tag_q   <= tag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        tag_d   = tag_q;
        issue   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                    row_d   = '0;
                    col_d   = '0;
                    tag_d   = '0;
                end
            end
            StRun: begin
                if (!pause_i) begin
                    issue = 1'b1;
                    // Running tag replaces row*COLS+col, avoiding a multiplier.
                    tag_d = tag_q + 1'b1;
                    if (col_q == ColLast) begin
                        col_d = '0;
                        if (row_q == RowLast) begin
                            row_d   = '0;
                            state_d = StDrain;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (!any_valid) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    matmul_valid_pipe #(
        .DEPTH (PipeDepth),
        .TAG_W (OUT_ADDR_WIDTH)
    ) u_valid_pipe (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .valid_i     (issue),
        .tag_i       (tag_q),
        .valid_o     (we_out_o),
        .tag_o       (addr_out_o),
        .any_valid_o (any_valid)
    );

    assign busy     = (state_q == StRun) || (state_q == StDrain);
    assign en_a_o   = issue;
    assign en_b_o   = issue;
    assign addr_a_o = row_q;
    assign addr_b_o = col_q;
    assign en_out_o = we_out_o;
    assign busy_o   = busy;
    assign done_o   = (state_q == StFin);

`ifdef MATMUL_SEQ_PERF_CNT_EN
    logic [31:0] cycle_count_q, cycle_count_d;
    logic [31:0] pause_count_q, pause_count_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cycle_count_q <= '0;
            pause_count_q <= '0;
        end else begin
            cycle_count_q <= cycle_count_d;
            pause_count_q <= pause_count_d;
        end
    end

    always_comb begin
        cycle_count_d = cycle_count_q;
        pause_count_d = pause_count_q;
        if (state_q == StIdle && start_i) begin
            cycle_count_d = '0;
            pause_count_d = '0;
        end else begin
            if (busy) begin
                cycle_count_d = cycle_count_q + 32'd1;
            end
            if (state_q == StRun && pause_i) begin
                pause_count_d = pause_count_q + 32'd1;
            end
        end
    end

    assign cycle_count_o = cycle_count_q;
    assign pause_count_o = pause_count_q;
`endif

endmodule
